// File: rtl/math_abs_scheduler.sv
// Round-robin arbiter in front of one absolute-value unit: IDLE grants a requester, CALC computes, RESP holds the result.
// Optional build macro MATH_ABS_SAT_EN saturates abs(-2^(W-1)) to 2^(W-1)-1 instead of wrapping.
module math_abs_scheduler #(
  parameter int N_REQ_P      = 4,
  parameter int DATA_WIDTH_P = 32,
  localparam int ID_WIDTH_C  = $clog2(N_REQ_P)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ_P-1:0]              req_valid,
  output logic [N_REQ_P-1:0]              req_ready,
  input  logic [N_REQ_P*DATA_WIDTH_P-1:0] req_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH_P-1:0]         rsp_data,
  output logic [ID_WIDTH_C-1:0]           rsp_id,
  output logic                            rsp_ovf,
  output logic [15:0]                     op_cnt
);

  localparam logic [DATA_WIDTH_P-1:0] MIN_C = {1'b1, {(DATA_WIDTH_P-1){1'b0}}};
  localparam logic [DATA_WIDTH_P-1:0] MAX_C = {1'b0, {(DATA_WIDTH_P-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ID_WIDTH_C-1:0]   r_rr_ptr;
  logic [ID_WIDTH_C-1:0]   r_id;
  logic [DATA_WIDTH_P-1:0] r_operand;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH_P-1:0] r_rsp_data;
  logic [ID_WIDTH_C-1:0]   r_rsp_id;
  logic                    r_rsp_ovf;
  logic [15:0]             r_op_cnt;

  logic                    w_grant_any;
  logic [ID_WIDTH_C-1:0]   w_grant_idx;
  logic [DATA_WIDTH_P-1:0] w_abs;
  logic                    w_ovf;

  function automatic logic [ID_WIDTH_C-1:0] rr_index(input logic [ID_WIDTH_C-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ_P) begin
      sum = sum - N_REQ_P;
    end
    return ID_WIDTH_C'(sum);
  endfunction

  // Descending scan so the requester closest to r_rr_ptr overwrites the others.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = N_REQ_P - 1; k >= 0; k--) begin
      if (req_valid[rr_index(r_rr_ptr, k)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = rr_index(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == S_IDLE) && w_grant_any) begin
      req_ready[w_grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    w_ovf = (r_operand == MIN_C);
    if (r_operand[DATA_WIDTH_P-1]) begin
`ifdef MATH_ABS_SAT_EN
      w_abs = w_ovf ? MAX_C : (~r_operand + DATA_WIDTH_P'(1));
`else
      w_abs = ~r_operand + DATA_WIDTH_P'(1);
`endif
    end else begin
      w_abs = r_operand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_operand   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_ovf   <= 1'b0;
      r_op_cnt    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A grant implies its req_valid bit is high, so a grant is a handshake.
          if (w_grant_any) begin
            r_operand <= req_data[w_grant_idx*DATA_WIDTH_P +: DATA_WIDTH_P];
            r_id      <= w_grant_idx;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_rsp_data  <= w_abs;
          r_rsp_ovf   <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= rr_index(r_id, 1);
            r_op_cnt    <= r_op_cnt + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_ovf   = r_rsp_ovf;
  assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_math_abs_scheduler.sv
// Self-checking bench for math_abs_scheduler (N_REQ_P=4, DATA_WIDTH_P=32): vector table, scoreboard queue, corner sequences.
module tb_math_abs_scheduler;

  localparam int N = 4;
  localparam int W = 32;
`ifdef MATH_ABS_SAT_EN
  localparam logic [W-1:0] MIN_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [W-1:0] MIN_EXP = 32'h8000_0000;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ovf;
  logic [15:0]    op_cnt;

  math_abs_scheduler #(.N_REQ_P(N), .DATA_WIDTH_P(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ovf(rsp_ovf), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [W-1:0] d);
    exp_t e;
    e.id  = 2'(id);
    e.ovf = (d == 32'h8000_0000);
    if (e.ovf)       e.data = MIN_EXP;
    else if (d[W-1]) e.data = 32'd0 - d;
    else             e.data = d;
    return e;
  endfunction

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got response id %0d, want an expected entry", rsp_id);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
    end
  endtask

  task automatic do_single(input int id, input logic [W-1:0] d, input logic [W-1:0] ed, input logic eo);
    exp_t e;
    @(negedge clk);
    req_valid = 4'(1 << id);
    req_data[id*W +: W] = d;
    rsp_ready = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(1 << id));
    e.id = 2'(id); e.data = ed; e.ovf = eo;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("calc_valid", 32'(rsp_valid), 32'd0);
    chk("calc_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(rsp_valid), 32'd1);
    pop_cmp();
    exp_cnt++;
    @(negedge clk);
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("op_cnt", 32'(op_cnt), 32'(exp_cnt[15:0]));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [W-1:0] d;
    int got, n_grant, gid, rid;
    int exp_ids[5] = '{0, 1, 2, 3, 0};

    vecs[0] = '{2, 32'hFFFF_FFFB, 32'h0000_0005, 1'b0};
    vecs[1] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{1, 32'h0000_0007, 32'h0000_0007, 1'b0};
    vecs[3] = '{3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    vecs[4] = '{0, 32'h8000_0000, MIN_EXP,       1'b1};
    vecs[5] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[6] = '{3, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[7] = '{2, 32'h0000_0001, 32'h0000_0001, 1'b0};

    // Reset state, with every requester asking.
    rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ovf", 32'(rsp_ovf), 32'd0);
    chk("rst_cnt", 32'(op_cnt), 32'd0);
    req_valid = 4'h0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_single(vecs[i].id, vecs[i].data, vecs[i].exp_data, vecs[i].exp_ovf);
    end

    // Fairness with all four requesters held valid.
    pulse_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'd0 - 32'(i + 1);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    got = 0; n_grant = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      #1;
      if (req_ready != 4'h0) begin
        gid = 0;
        for (int b = 0; b < N; b++) if (req_ready[b]) gid = b;
        if (n_grant < 5) chk("fair_id", 32'(gid), 32'(exp_ids[n_grant]));
        n_grant++;
        sb_q.push_back(model(gid, 32'd0 - 32'(gid + 1)));
      end
      if (rsp_valid) begin
        pop_cmp();
        got++;
        exp_cnt++;
        if (got == 5) req_valid = 4'h0;
      end
      @(negedge clk);
    end
    chk("fair_done", 32'(got), 32'd5);
    @(negedge clk);
    chk("fair_cnt", 32'(op_cnt), 32'(exp_cnt));

    // Backpressure: result held for 10 cycles while requester 0 waits.
    req_valid = 4'b0010; req_data[1*W +: W] = 32'hFFFF_FFF7; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    sb_q.push_back(model(1, 32'hFFFF_FFF7));
    @(negedge clk);
    req_valid = 4'b0001; req_data[0*W +: W] = 32'd11;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd9);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      if (i < 9) @(negedge clk);
    end
    pop_cmp();
    exp_cnt++;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", 32'(rsp_valid), 32'd0);
    chk("bp_cnt", 32'(op_cnt), 32'(exp_cnt));
    chk("bp_next", 32'(req_ready), 32'b0001);
    sb_q.push_back(model(0, 32'd11));
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    chk("bp2_valid", 32'(rsp_valid), 32'd1);
    pop_cmp();
    exp_cnt++;
    @(negedge clk);
    chk("bp2_cnt", 32'(op_cnt), 32'(exp_cnt));

    // Reset while a result is pending in RESP clears the outputs at once.
    rsp_ready = 1'b0;
    req_valid = 4'b0100; req_data[2*W +: W] = 32'hFFFF_FFFA;
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    chk("rr_resp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_valid_now", 32'(rsp_valid), 32'd0);
    chk("rr_data_now", rsp_data, 32'd0);
    chk("rr_cnt_now", 32'(op_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    exp_cnt = 0;

    // Leave rr_ptr nonzero, then reset during CALC.
    do_single(1, 32'd3, 32'd3, 1'b0);
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'h0;
    rst = 1'b1;
    #1;
    chk("rc_valid", 32'(rsp_valid), 32'd0);
    chk("rc_cnt", 32'(op_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    rid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) rid++;
    end
    chk("rc_no_rsp", 32'(rid), 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("rc_rrptr", 32'(req_ready), 32'b0001);
    req_valid = 4'h0;
    do_single(3, 32'hFFFF_FFEC, 32'd20, 1'b0);

    // Random single operations keep the counter and datapath honest.
    for (int i = 0; i < 40; i++) begin
      gid = $urandom_range(0, N - 1);
      d = (i % 8 == 5) ? 32'h8000_0000 : 32'($urandom);
      e = model(gid, d);
      do_single(gid, d, e.data, e.ovf);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
